// File: rtl/led_sequencer.sv
// Pattern playback controller for the four-RGB-LED blink driver.
// Idle shows all colours plus a cursor blink; playback lights one LED per step.
module led_sequencer #(
    parameter int         ON_TICKS  = 8,
    parameter int         OFF_TICKS = 4,
    parameter logic [2:0] COLOR0    = 3'b100,
    parameter logic [2:0] COLOR1    = 3'b010,
    parameter logic [2:0] COLOR2    = 3'b001,
    parameter logic [2:0] COLOR3    = 3'b110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] seq_len,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [1:0] wr_data,
    input  logic       cursor_en,
    input  logic [1:0] cursor,
    output logic [2:0] rgb1,
    output logic [2:0] rgb2,
    output logic [2:0] rgb3,
    output logic [2:0] rgb4,
    output logic       blink_enable,
    output logic [1:0] blink_led,
    output logic       busy,
    output logic [3:0] step,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [7:0] ON_LAST  = 8'(ON_TICKS - 1);
    localparam logic [7:0] OFF_LAST = 8'(OFF_TICKS - 1);

    state_t     state;
    logic [3:0] step_q;
    logic [4:0] len;
    logic [7:0] tcnt;
    logic [1:0] mem [16];
    logic [1:0] cur;
    logic [4:0] eff_len;
    logic       active;

    assign active  = (state != S_IDLE);
    assign eff_len = (seq_len > 5'd16) ? 5'd16 : seq_len;
    assign cur     = mem[step_q];

    // Pattern memory survives reset so a loaded pattern can be replayed.
    always_ff @(posedge clk) begin
        if (wr_en && !active) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            step_q <= '0;
            len    <= '0;
            tcnt   <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            tcnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (eff_len == 5'd0) begin
                            state <= S_DONE;
                        end else begin
                            len    <= eff_len;
                            step_q <= '0;
                            tcnt   <= '0;
                            state  <= S_ON;
                        end
                    end
                end
                S_ON: begin
                    if (tick) begin
                        if (tcnt == ON_LAST) begin
                            tcnt  <= '0;
                            state <= S_GAP;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (tcnt == OFF_LAST) begin
                            tcnt <= '0;
                            if ({1'b0, step_q} == len - 5'd1) begin
                                state <= S_DONE;
                            end else begin
                                step_q <= step_q + 4'd1;
                                state  <= S_ON;
                            end
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced to their reset values for the whole reset cycle.
    always_comb begin
        rgb1         = 3'b000;
        rgb2         = 3'b000;
        rgb3         = 3'b000;
        rgb4         = 3'b000;
        blink_enable = 1'b0;
        blink_led    = 2'd0;
        busy         = 1'b0;
        done         = 1'b0;
        step         = rst ? 4'd0 : step_q;
        if (!rst) begin
            unique case (state)
                S_IDLE: begin
                    rgb1         = COLOR0;
                    rgb2         = COLOR1;
                    rgb3         = COLOR2;
                    rgb4         = COLOR3;
                    blink_enable = cursor_en;
                    blink_led    = cursor;
                end
                S_ON: begin
                    busy = 1'b1;
                    unique case (cur)
                        2'd0: rgb1 = COLOR0;
                        2'd1: rgb2 = COLOR1;
                        2'd2: rgb3 = COLOR2;
                        2'd3: rgb4 = COLOR3;
                        default: rgb1 = 3'b000;
                    endcase
                end
                S_GAP: begin
                    busy = 1'b1;
                end
                S_DONE: begin
                    busy = 1'b1;
                    done = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomised and directed check of led_sequencer against a tick-position model.
// Playback is modelled as a tick count into a len*(ON+OFF) timeline.
module tb_led_sequencer;

    localparam int ON_T  = 2;
    localparam int OFF_T = 1;
    localparam int PER   = ON_T + OFF_T;

    logic       clk = 1'b0;
    logic       rst, tick, start, abort, wr_en, cursor_en;
    logic [4:0] seq_len;
    logic [3:0] wr_addr;
    logic [1:0] wr_data, cursor;
    logic [2:0] rgb1, rgb2, rgb3, rgb4;
    logic       blink_enable;
    logic [1:0] blink_led;
    logic       busy, done;
    logic [3:0] step;

    always #5 clk = ~clk;

    led_sequencer #(
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .abort       (abort),
        .seq_len     (seq_len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cursor_en   (cursor_en),
        .cursor      (cursor),
        .rgb1        (rgb1),
        .rgb2        (rgb2),
        .rgb3        (rgb3),
        .rgb4        (rgb4),
        .blink_enable(blink_enable),
        .blink_led   (blink_led),
        .busy        (busy),
        .step        (step),
        .done        (done)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model state
    bit         m_play = 0;
    bit         m_done = 0;
    int         m_p    = 0;
    int         m_len  = 0;
    logic [1:0] m_mem [16];

    int  tk_cnt    = 0;
    int  done_seen = 0;
    int  lit2      = 0;
    bit  prev2     = 0;

    function automatic logic [2:0] color(int i);
        case (i)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            default: return 3'b110;
        endcase
    endfunction

    task automatic cmp(string nm, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    logic [2:0] er [4];
    logic       e_be, e_busy, e_done;
    logic [1:0] e_bl;
    int         e_step;
    bit         sv;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) er[i] = 3'b000;
        e_be = 0; e_bl = 0; e_busy = 0; e_done = 0;
        e_step = 0; sv = 1;
        if (!rst) begin
            if (m_done) begin
                e_busy = 1; e_done = 1;
                if (m_len > 0) e_step = m_len - 1;
                else sv = 0;
            end else if (m_play) begin
                e_busy = 1;
                e_step = m_p / PER;
                if (m_p % PER < ON_T)
                    er[m_mem[e_step]] = color(int'(m_mem[e_step]));
            end else begin
                for (int i = 0; i < 4; i++) er[i] = color(i);
                e_be = cursor_en;
                e_bl = cursor;
                sv = 0;
            end
        end
        cmp("rgb1", int'(rgb1), int'(er[0]));
        cmp("rgb2", int'(rgb2), int'(er[1]));
        cmp("rgb3", int'(rgb3), int'(er[2]));
        cmp("rgb4", int'(rgb4), int'(er[3]));
        cmp("blink_enable", int'(blink_enable), int'(e_be));
        cmp("blink_led", int'(blink_led), int'(e_bl));
        cmp("busy", int'(busy), int'(e_busy));
        cmp("done", int'(done), int'(e_done));
        if (sv) cmp("step", int'(step), e_step);
    end

    task automatic cyc();
        bit n_play, n_done, wr;
        int n_p, n_len, l;
        @(negedge clk);
        n_play = m_play; n_done = m_done;
        n_p = m_p; n_len = m_len;
        wr = wr_en && !(m_play || m_done);
        if (rst || abort) begin
            n_play = 0; n_done = 0;
        end else if (m_done) begin
            n_done = 0;
        end else if (m_play) begin
            if (tick) begin
                n_p = m_p + 1;
                if (n_p == m_len * PER) begin
                    n_play = 0; n_done = 1;
                end
            end
        end else if (start) begin
            l = (seq_len > 16) ? 16 : int'(seq_len);
            n_len = l;
            if (l == 0) n_done = 1;
            else begin
                n_play = 1; n_p = 0;
            end
        end
        @(posedge clk);
        m_play = n_play; m_done = n_done;
        m_p = n_p; m_len = n_len;
        if (wr) m_mem[wr_addr] = wr_data;
        #1;
        if (done) done_seen++;
        if (busy && rgb2 == 3'b010 && !prev2) lit2++;
        prev2 = busy && (rgb2 == 3'b010);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            tick = (tk_cnt % 4 == 3);
            tk_cnt++;
            cyc();
            start = 0; abort = 0; wr_en = 0;
        end
    endtask

    task automatic wr(int a, int d);
        wr_en = 1; wr_addr = 4'(a); wr_data = 2'(d);
        run(1);
    endtask

    task automatic go(int l);
        start = 1; seq_len = 5'(l);
        run(1);
    endtask

    bit hit;

    initial begin
        rst = 1; tick = 0; start = 0; abort = 0; wr_en = 0;
        seq_len = 0; wr_addr = 0; wr_data = 0;
        cursor_en = 1; cursor = 2;
        run(2);
        cmp("rst_busy", int'(busy), 0);
        rst = 0;
        run(1);
        cmp("idle_rgb1", int'(rgb1), 4);
        cmp("idle_rgb4", int'(rgb4), 6);
        cmp("idle_be", int'(blink_enable), 1);
        cmp("idle_bl", int'(blink_led), 2);
        cmp("idle_busy", int'(busy), 0);

        wr(0, 3); wr(1, 0); wr(2, 1);
        done_seen = 0;
        go(3);
        cmp("p1_rgb4", int'(rgb4), 6);
        cmp("p1_rgb1", int'(rgb1), 0);
        run(44);
        cmp("p1_done_cnt", done_seen, 1);
        cmp("p1_end_busy", int'(busy), 0);

        go(0);
        cmp("z_done", int'(done), 1);
        cmp("z_busy", int'(busy), 1);
        cmp("z_rgb4", int'(rgb4), 0);
        run(1);
        cmp("z_done_off", int'(done), 0);

        done_seen = 0;
        hit = 0;
        go(3);
        for (int i = 0; i < 60 && !hit; i++) begin
            tick = (tk_cnt % 4 == 3);
            tk_cnt++;
            if (m_play && m_p == 4 && tick) begin
                abort = 1; hit = 1;
            end
            cyc();
            abort = 0;
        end
        cmp("abort_hit", int'(hit), 1);
        cmp("abort_busy", int'(busy), 0);
        run(3);
        cmp("abort_no_done", done_seen, 0);
        go(3);
        cmp("replay_rgb4", int'(rgb4), 6);
        run(44);

        done_seen = 0;
        go(3);
        for (int i = 0; i < 6; i++) begin
            wr_en = 1; wr_addr = 0; wr_data = 2;
            start = 1; seq_len = 1;
            run(1);
        end
        run(44);
        cmp("busy_wr_done", done_seen, 1);
        go(1);
        cmp("mem_kept", int'(rgb4), 6);
        run(16);
        wr(0, 2);
        go(1);
        cmp("mem_new", int'(rgb3), 1);
        run(16);

        for (int i = 0; i < 16; i++) wr(i, 1);
        done_seen = 0; lit2 = 0;
        go(16);
        run(200);
        cmp("l16_lit", lit2, 16);
        cmp("l16_done", done_seen, 1);
        go(16);
        run(10);
        rst = 1;
        run(1);
        cmp("mid_rst_rgb2", int'(rgb2), 0);
        cmp("mid_rst_busy", int'(busy), 0);
        rst = 0;
        run(1);
        cmp("post_rst_rgb1", int'(rgb1), 4);

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(399) == 0);
            tick      = ($urandom_range(2) == 0);
            start     = ($urandom_range(19) == 0);
            abort     = ($urandom_range(79) == 0);
            seq_len   = ($urandom_range(3) == 0) ?
                        5'($urandom_range(31)) : 5'($urandom_range(4));
            wr_en     = ($urandom_range(7) == 0);
            wr_addr   = 4'($urandom_range(15));
            wr_data   = 2'($urandom_range(3));
            cursor_en = 1'($urandom_range(1));
            cursor    = 2'($urandom_range(3));
            cyc();
        end
        rst = 0; start = 0; abort = 0; wr_en = 0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
